// File: rtl/toy_pack.sv
// Shared types and widths for the instruction-fetch path.
package toy_pack;

  localparam int unsigned ICACHE_REQ_OPCODE_WIDTH = 2;
  localparam int unsigned MSHR_ENTRY_INDEX_WIDTH  = 4;
  localparam int unsigned ROB_ENTRY_ID_WIDTH      = 6;
  localparam int unsigned ICACHE_LINE_WIDTH       = 512;
  localparam int unsigned PC_WIDTH                = 32;

  localparam logic [ICACHE_REQ_OPCODE_WIDTH-1:0] ICACHE_OPCODE_READ = 2'd1;

  typedef logic [PC_WIDTH-1:0] req_addr_t;

  typedef struct packed {
    req_addr_t                     addr;
    logic [ROB_ENTRY_ID_WIDTH-1:0] rob_id;
  } pc_req_t;

  typedef struct packed {
    logic [ICACHE_LINE_WIDTH-1:0]      data;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0] mshr_id;
  } downstream_rxdat_t;

  typedef enum logic [1:0] {
    ADP_IDLE = 2'd0,
    ADP_BUSY = 2'd1,
    ADP_RESP = 2'd2
  } adapter_state_e;

endpackage

// File: rtl/icache_mem_adapter.sv
// Splits one cache-line refill into fetch-width memory reads and reassembles
// the returned beats (any order) into a line for the icache.
module icache_mem_adapter
  import toy_pack::*;
#(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned FETCH_DATA_WIDTH = 256,
  parameter int unsigned LINE_WIDTH       = 512,
  parameter int unsigned ID_WIDTH         = ICACHE_REQ_OPCODE_WIDTH + MSHR_ENTRY_INDEX_WIDTH
                                            + ROB_ENTRY_ID_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              downstream_txreq_vld,
  output logic                              downstream_txreq_rdy,
  input  pc_req_t                           downstream_txreq_pld,
  input  logic [MSHR_ENTRY_INDEX_WIDTH-1:0] downstream_txreq_entry_id,
  output logic                              downstream_rxdat_vld,
  input  logic                              downstream_rxdat_rdy,
  output downstream_rxdat_t                 downstream_rxdat_pld,
  output logic                              adapter_fetch_mem_req_vld,
  input  logic                              adapter_fetch_mem_req_rdy,
  output logic [ADDR_WIDTH-1:0]             adapter_fetch_mem_req_addr,
  output logic [ID_WIDTH-1:0]               adapter_fetch_mem_req_entry_id,
  input  logic                              adapter_fetch_mem_ack_vld,
  output logic                              adapter_fetch_mem_ack_rdy,
  input  logic [FETCH_DATA_WIDTH-1:0]       adapter_fetch_mem_ack_data,
  input  logic [ID_WIDTH-1:0]               adapter_fetch_mem_ack_entry_id
);

  localparam int unsigned BEATS      = LINE_WIDTH / FETCH_DATA_WIDTH;
  localparam int unsigned IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W      = $clog2(BEATS + 1);
  localparam int unsigned LINE_BYTES = LINE_WIDTH / 8;
  localparam int unsigned BEAT_BYTES = FETCH_DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

  adapter_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0]             line_addr_q, line_addr_d;
  logic [MSHR_ENTRY_INDEX_WIDTH-1:0] mshr_q, mshr_d;
  logic [CNT_W-1:0]                  req_cnt_q, req_cnt_d;
  logic [BEATS-1:0]                  ack_mask_q, ack_mask_d;
  logic [LINE_WIDTH-1:0]             line_q, line_d;

  logic [MSHR_ENTRY_INDEX_WIDTH-1:0] ack_mshr;
  logic [IDX_W-1:0]                  ack_idx;
  logic [IDX_W-1:0]                  req_idx;
  logic                              ack_hit;
  logic                              req_vld;
  logic [ADDR_WIDTH-1:0]             req_addr;
  logic [ID_WIDTH-1:0]               req_id;
  logic                              unused_ok;

  // Ack id layout is {opcode, mshr, beat}; the opcode is not checked.
  assign ack_mshr  = adapter_fetch_mem_ack_entry_id[ROB_ENTRY_ID_WIDTH +: MSHR_ENTRY_INDEX_WIDTH];
  assign ack_idx   = (BEATS > 1) ? adapter_fetch_mem_ack_entry_id[IDX_W-1:0] : '0;
  assign unused_ok = ^{downstream_txreq_pld.rob_id,
                       adapter_fetch_mem_ack_entry_id[ID_WIDTH-1 -: ICACHE_REQ_OPCODE_WIDTH],
                       adapter_fetch_mem_ack_entry_id[ROB_ENTRY_ID_WIDTH-1:0]};

  assign req_idx  = req_cnt_q[IDX_W-1:0];
  assign req_vld  = (state_q == ADP_BUSY) && (req_cnt_q < CNT_W'(BEATS));
  assign req_addr = line_addr_q + ADDR_WIDTH'(req_cnt_q) * ADDR_WIDTH'(BEAT_BYTES);
  assign req_id   = {ICACHE_OPCODE_READ, mshr_q, ROB_ENTRY_ID_WIDTH'(req_idx)};

  assign ack_hit = adapter_fetch_mem_ack_vld && (state_q == ADP_BUSY)
                   && (ack_mshr == mshr_q) && !ack_mask_q[ack_idx];

  assign adapter_fetch_mem_ack_rdy      = 1'b1;
  assign adapter_fetch_mem_req_vld      = req_vld;
  assign adapter_fetch_mem_req_addr     = req_vld ? req_addr : '0;
  assign adapter_fetch_mem_req_entry_id = req_vld ? req_id : '0;

  always_comb begin
    state_d              = state_q;
    line_addr_d          = line_addr_q;
    mshr_d               = mshr_q;
    req_cnt_d            = req_cnt_q;
    ack_mask_d           = ack_mask_q;
    line_d               = line_q;
    downstream_txreq_rdy = 1'b0;
    downstream_rxdat_vld = 1'b0;
    downstream_rxdat_pld = '0;

    case (state_q)
      ADP_IDLE: begin
        downstream_txreq_rdy = 1'b1;
        if (downstream_txreq_vld) begin
          line_addr_d = ADDR_WIDTH'(downstream_txreq_pld.addr) & LINE_MASK;
          mshr_d      = downstream_txreq_entry_id;
          req_cnt_d   = '0;
          ack_mask_d  = '0;
          state_d     = ADP_BUSY;
        end
      end
      ADP_BUSY: begin
        if (req_vld && adapter_fetch_mem_req_rdy) begin
          req_cnt_d = req_cnt_q + 1'b1;
        end
        if (ack_hit) begin
          line_d[ack_idx*FETCH_DATA_WIDTH +: FETCH_DATA_WIDTH] = adapter_fetch_mem_ack_data;
          ack_mask_d[ack_idx] = 1'b1;
        end
        // Uses the updated mask so a final ack completes the line this cycle.
        if (&ack_mask_d) begin
          state_d = ADP_RESP;
        end
      end
      ADP_RESP: begin
        downstream_rxdat_vld         = 1'b1;
        downstream_rxdat_pld.data    = line_q;
        downstream_rxdat_pld.mshr_id = mshr_q;
        if (downstream_rxdat_rdy) begin
          state_d = ADP_IDLE;
        end
      end
      default: state_d = ADP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ADP_IDLE;
      line_addr_q <= '0;
      mshr_q      <= '0;
      req_cnt_q   <= '0;
      ack_mask_q  <= '0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      mshr_q      <= mshr_d;
      req_cnt_q   <= req_cnt_d;
      ack_mask_q  <= ack_mask_d;
      line_q      <= line_d;
    end
  end

endmodule

// File: tb/tb_icache_mem_adapter.sv
// Directed self-checking bench for icache_mem_adapter (default parameters).
module tb_icache_mem_adapter;
  import toy_pack::*;

  logic              clk;
  logic              rst_n;
  logic              txreq_vld;
  logic              txreq_rdy;
  pc_req_t           txreq_pld;
  logic [3:0]        txreq_mshr;
  logic              rxdat_vld;
  logic              rxdat_rdy;
  downstream_rxdat_t rxdat_pld;
  logic              mreq_vld;
  logic              mreq_rdy;
  logic [31:0]       mreq_addr;
  logic [11:0]       mreq_id;
  logic              mack_vld;
  logic              mack_rdy;
  logic [255:0]      mack_data;
  logic [11:0]       mack_id;

  int checks;
  int errors;

  icache_mem_adapter #(
    .ADDR_WIDTH      (32),
    .FETCH_DATA_WIDTH(256),
    .LINE_WIDTH      (512),
    .ID_WIDTH        (12)
  ) dut (
    .clk                           (clk),
    .rst_n                         (rst_n),
    .downstream_txreq_vld          (txreq_vld),
    .downstream_txreq_rdy          (txreq_rdy),
    .downstream_txreq_pld          (txreq_pld),
    .downstream_txreq_entry_id     (txreq_mshr),
    .downstream_rxdat_vld          (rxdat_vld),
    .downstream_rxdat_rdy          (rxdat_rdy),
    .downstream_rxdat_pld          (rxdat_pld),
    .adapter_fetch_mem_req_vld     (mreq_vld),
    .adapter_fetch_mem_req_rdy     (mreq_rdy),
    .adapter_fetch_mem_req_addr    (mreq_addr),
    .adapter_fetch_mem_req_entry_id(mreq_id),
    .adapter_fetch_mem_ack_vld     (mack_vld),
    .adapter_fetch_mem_ack_rdy     (mack_rdy),
    .adapter_fetch_mem_ack_data    (mack_data),
    .adapter_fetch_mem_ack_entry_id(mack_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mshr;
    bit          ooo;
    logic [31:0] ea0;
    logic [31:0] ea1;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [255:0] bd(input logic [31:0] a);
    return {a, ~a, a ^ 32'h1234_5678, a + 32'd1, {a[15:0], a[31:16]},
            a ^ 32'hFFFF_0000, a - 32'd1, 32'hC0DE_0000 | {16'h0, a[15:0]}};
  endfunction

  function automatic logic [11:0] rid(input logic [3:0] m, input int b);
    return {2'b01, m, 6'(b)};
  endfunction

  task automatic chk(input string nm, input logic [575:0] act, input logic [575:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_txreq(input logic [31:0] a, input logic [3:0] m);
    txreq_vld      = 1'b1;
    txreq_pld.addr = a;
    txreq_mshr     = m;
    tick();
    txreq_vld = 1'b0;
  endtask

  task automatic send_ack(input logic [1:0] op, input logic [3:0] m, input int b,
                          input logic [255:0] d);
    mack_vld  = 1'b1;
    mack_id   = {op, m, 6'(b)};
    mack_data = d;
    tick();
    mack_vld = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_txreq_rdy"}, 576'(txreq_rdy), 576'd1);
    chk({tag, "_rxdat_vld"}, 576'(rxdat_vld), 576'd0);
    chk({tag, "_rxdat_pld"}, 576'(rxdat_pld), 576'd0);
    chk({tag, "_mreq_vld"},  576'(mreq_vld),  576'd0);
    chk({tag, "_mreq_addr"}, 576'(mreq_addr), 576'd0);
    chk({tag, "_mreq_id"},   576'(mreq_id),   576'd0);
    chk({tag, "_ack_rdy"},   576'(mack_rdy),  576'd1);
  endtask

  task automatic take_rxdat();
    rxdat_rdy = 1'b1;
    tick();
    rxdat_rdy = 1'b0;
    @(negedge clk);
    chk("rxdat_vld_after_hs", 576'(rxdat_vld), 576'd0);
    chk("txreq_rdy_after_hs", 576'(txreq_rdy), 576'd1);
  endtask

  task automatic refill(input vec_t v);
    logic [31:0] ra[2];
    logic [11:0] ri[2];
    int n;
    int guard;
    int first;
    logic [1:0] op;
    n     = 0;
    guard = 0;
    first = -1;
    op    = v.ooo ? 2'b10 : 2'b01;
    chk("txreq_rdy_idle", 576'(txreq_rdy), 576'd1);
    send_txreq(v.addr, v.mshr);
    mreq_rdy = 1'b1;
    while (n < 2 && guard < 20) begin
      @(negedge clk);
      if (mreq_vld) begin
        if (first < 0) first = guard;
        ra[n] = mreq_addr;
        ri[n] = mreq_id;
        n++;
      end
      tick();
      guard++;
    end
    chk("req_count", 576'(n), 576'd2);
    chk("first_req_latency", 576'(first), 576'd0);
    chk("req0_addr", 576'(ra[0]), 576'(v.ea0));
    chk("req1_addr", 576'(ra[1]), 576'(v.ea1));
    chk("req0_id", 576'(ri[0]), 576'(rid(v.mshr, 0)));
    chk("req1_id", 576'(ri[1]), 576'(rid(v.mshr, 1)));
    @(negedge clk);
    chk("req_vld_done", 576'(mreq_vld), 576'd0);
    chk("rxdat_early", 576'(rxdat_vld), 576'd0);
    if (v.ooo) begin
      send_ack(op, v.mshr, 1, bd(v.ea1));
      send_ack(op, v.mshr, 0, bd(v.ea0));
    end else begin
      send_ack(op, v.mshr, 0, bd(v.ea0));
      send_ack(op, v.mshr, 1, bd(v.ea1));
    end
    @(negedge clk);
    chk("rxdat_vld", 576'(rxdat_vld), 576'd1);
    chk("rxdat_mshr", 576'(rxdat_pld.mshr_id), 576'(v.mshr));
    chk("rxdat_data", 576'(rxdat_pld.data), 576'({bd(v.ea1), bd(v.ea0)}));
    chk("txreq_rdy_resp", 576'(txreq_rdy), 576'd0);
    take_rxdat();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    txreq_vld = 1'b0;
    txreq_pld = '0;
    txreq_mshr = '0;
    rxdat_rdy = 1'b0;
    mreq_rdy  = 1'b1;
    mack_vld  = 1'b0;
    mack_data = '0;
    mack_id   = '0;

    // Addresses are line-aligned to 64 bytes before splitting into 32-byte beats.
    vecs[0] = '{addr: 32'h0000_1000, mshr: 4'd3,  ooo: 1'b0, ea0: 32'h0000_1000, ea1: 32'h0000_1020};
    vecs[1] = '{addr: 32'h0000_1034, mshr: 4'd3,  ooo: 1'b0, ea0: 32'h0000_1000, ea1: 32'h0000_1020};
    vecs[2] = '{addr: 32'h0000_1000, mshr: 4'd3,  ooo: 1'b1, ea0: 32'h0000_1000, ea1: 32'h0000_1020};
    vecs[3] = '{addr: 32'h0000_2074, mshr: 4'd0,  ooo: 1'b0, ea0: 32'h0000_2040, ea1: 32'h0000_2060};
    vecs[4] = '{addr: 32'hFFFF_FFC8, mshr: 4'd15, ooo: 1'b1, ea0: 32'hFFFF_FFC0, ea1: 32'hFFFF_FFE0};
    vecs[5] = '{addr: 32'h0000_2000, mshr: 4'd7,  ooo: 1'b1, ea0: 32'h0000_2000, ea1: 32'h0000_2020};

    #3;
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) refill(vecs[i]);

    // Memory request backpressure, then response backpressure.
    send_txreq(32'h0000_3000, 4'd3);
    mreq_rdy = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_req_vld", 576'(mreq_vld), 576'd1);
      chk("bp_req_addr", 576'(mreq_addr), 576'h3000);
      chk("bp_req_id", 576'(mreq_id), 576'(rid(4'd3, 0)));
      tick();
    end
    mreq_rdy = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_req1_addr", 576'(mreq_addr), 576'h3020);
    chk("bp_req1_id", 576'(mreq_id), 576'(rid(4'd3, 1)));
    tick();
    send_ack(2'b01, 4'd3, 0, bd(32'h3000));
    send_ack(2'b01, 4'd3, 1, bd(32'h3020));
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_rxdat_vld", 576'(rxdat_vld), 576'd1);
      chk("bp_rxdat_pld", 576'(rxdat_pld), 576'({bd(32'h3020), bd(32'h3000), 4'd3}));
      chk("bp_txreq_rdy", 576'(txreq_rdy), 576'd0);
      tick();
    end
    take_rxdat();

    // Stray mshr and duplicate beat are consumed without effect.
    send_txreq(32'h0000_4000, 4'd3);
    tick();
    tick();
    send_ack(2'b01, 4'd3, 0, bd(32'h4000));
    send_ack(2'b01, 4'd5, 1, {8{32'hDEAD_BEEF}});
    @(negedge clk);
    chk("stray_no_rxdat", 576'(rxdat_vld), 576'd0);
    send_ack(2'b01, 4'd3, 0, {8{32'hBAD0_BAD0}});
    @(negedge clk);
    chk("dup_no_rxdat", 576'(rxdat_vld), 576'd0);
    send_ack(2'b01, 4'd3, 1, bd(32'h4020));
    @(negedge clk);
    chk("stray_rxdat_vld", 576'(rxdat_vld), 576'd1);
    chk("stray_rxdat_data", 576'(rxdat_pld.data), 576'({bd(32'h4020), bd(32'h4000)}));
    take_rxdat();

    // Final ack lands in the same cycle as the final request.
    send_txreq(32'h0000_5000, 4'd9);
    tick();
    mreq_rdy = 1'b0;
    send_ack(2'b01, 4'd9, 0, bd(32'h5000));
    @(negedge clk);
    chk("same_cyc_req1_pending", 576'(mreq_vld), 576'd1);
    mreq_rdy = 1'b1;
    send_ack(2'b01, 4'd9, 1, bd(32'h5020));
    @(negedge clk);
    chk("same_cyc_rxdat_vld", 576'(rxdat_vld), 576'd1);
    chk("same_cyc_req_done", 576'(mreq_vld), 576'd0);
    chk("same_cyc_data", 576'(rxdat_pld.data), 576'({bd(32'h5020), bd(32'h5000)}));
    take_rxdat();

    // Reset in the middle of a refill.
    send_txreq(32'h0000_1000, 4'd3);
    tick();
    tick();
    send_ack(2'b01, 4'd3, 0, bd(32'h1000));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    send_ack(2'b01, 4'd3, 1, bd(32'h1020));
    @(negedge clk);
    chk("late_ack_no_rxdat", 576'(rxdat_vld), 576'd0);
    chk("late_ack_txreq_rdy", 576'(txreq_rdy), 576'd1);
    chk("late_ack_no_req", 576'(mreq_vld), 576'd0);
    tick();
    refill(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
